// File: rtl/hub75_pkg.sv
// Shared HUB75 definitions: frame-buffer write mux FSM encoding and width helpers.
package hub75_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_GAP   = 2'd2
  } fbw_state_t;

  // Select width never collapses to zero, even for a two-source build.
  function automatic int sel_width(input int n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hub75_fbw_mux_timer.sv
// Drain timeout counter for hub75_fbw_mux; only instantiated when FBW_MUX_TIMEOUT_EN is defined.
module hub75_fbw_mux_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1 << 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  // Counts cycles spent in DRAIN; holding at zero outside DRAIN clears it on every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!run) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = run && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/hub75_fbw_mux.sv
// Frame-boundary switching multiplexer in front of the hub75_top frame-buffer write port.
// Optional drain timeout is enabled with `define FBW_MUX_TIMEOUT_EN.
module hub75_fbw_mux
  import hub75_pkg::*;
#(
  parameter int          N_SRC          = 3,
  parameter int          N_ROWS         = 64,
  parameter int          N_COLS         = 384,
  parameter int          BITDEPTH       = 16,
  parameter int          DEFAULT_SRC    = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1 << 20,
  localparam int         LR             = $clog2(N_ROWS),
  localparam int         LC             = $clog2(N_COLS),
  localparam int         LS             = sel_width(N_SRC)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_SRC*LR-1:0]       src_row_addr,
  input  logic [N_SRC-1:0]          src_row_store,
  input  logic [N_SRC-1:0]          src_row_swap,
  output logic [N_SRC-1:0]          src_row_rdy,
  input  logic [N_SRC*BITDEPTH-1:0] src_data,
  input  logic [N_SRC*LC-1:0]       src_col_addr,
  input  logic [N_SRC-1:0]          src_wren,
  input  logic [N_SRC-1:0]          src_frame_swap,
  output logic [N_SRC-1:0]          src_frame_rdy,
  output logic [LR-1:0]             fbw_row_addr,
  output logic                      fbw_row_store,
  output logic                      fbw_row_swap,
  output logic [BITDEPTH-1:0]       fbw_data,
  output logic [LC-1:0]             fbw_col_addr,
  output logic                      fbw_wren,
  output logic                      frame_swap,
  input  logic                      fbw_row_rdy,
  input  logic                      frame_rdy,
  input  logic [LS-1:0]             sel,
  input  logic                      sel_req,
  output logic [LS-1:0]             active,
  output logic                      switching,
  output logic                      timeout_flag
);

  localparam logic [LS:0]   N_SRC_W = (LS + 1)'(N_SRC);
  localparam logic [LS-1:0] DEF_SRC = LS'(DEFAULT_SRC);

  fbw_state_t        state, next_state;
  logic [LS-1:0]     pending, next_pending, next_active;
  logic [LR-1:0]     own_row_addr;
  logic [LC-1:0]     own_col_addr;
  logic [BITDEPTH-1:0] own_data;
  logic              own_row_store, own_row_swap, own_wren, own_frame_swap;
  logic              sel_valid, swap_acc, timeout_hit, go_gap, routed;

  always_comb begin
    own_row_addr   = '0;
    own_col_addr   = '0;
    own_data       = '0;
    own_row_store  = 1'b0;
    own_row_swap   = 1'b0;
    own_wren       = 1'b0;
    own_frame_swap = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (active == LS'(i)) begin
        own_row_addr   = src_row_addr[i*LR +: LR];
        own_col_addr   = src_col_addr[i*LC +: LC];
        own_data       = src_data[i*BITDEPTH +: BITDEPTH];
        own_row_store  = src_row_store[i];
        own_row_swap   = src_row_swap[i];
        own_wren       = src_wren[i];
        own_frame_swap = src_frame_swap[i];
      end
    end
  end

  assign sel_valid = sel_req && ({1'b0, sel} < N_SRC_W);
  assign swap_acc  = frame_swap && frame_rdy;

  // A cancel request wins over an accepted swap or timeout in the same cycle.
  always_comb begin
    next_state   = state;
    next_active  = active;
    next_pending = pending;
    go_gap       = 1'b0;
    case (state)
      ST_RUN: begin
        if (sel_valid && (sel != active)) begin
          next_pending = sel;
          next_state   = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (sel_valid && (sel == active)) begin
          next_state = ST_RUN;
        end else begin
          if (sel_valid) next_pending = sel;
          if (swap_acc || timeout_hit) begin
            next_state = ST_GAP;
            go_gap     = 1'b1;
          end
        end
      end
      ST_GAP: begin
        next_active = pending;
        next_state  = ST_RUN;
      end
      default: next_state = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_RUN;
      active  <= DEF_SRC;
      pending <= DEF_SRC;
    end else begin
      state   <= next_state;
      active  <= next_active;
      pending <= next_pending;
    end
  end

  // Readies close on the cycle DRAIN hands over, so nothing is captured for the GAP cycle.
  assign routed = rst_n && ((state == ST_RUN) || ((state == ST_DRAIN) && !go_gap));

  always_comb begin
    src_row_rdy   = '0;
    src_frame_rdy = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (routed && (active == LS'(i))) begin
        src_row_rdy[i]   = fbw_row_rdy && !(fbw_row_store || fbw_row_swap);
        src_frame_rdy[i] = frame_rdy && !frame_swap;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fbw_row_addr  <= '0;
      fbw_col_addr  <= '0;
      fbw_data      <= '0;
      fbw_row_store <= 1'b0;
      fbw_row_swap  <= 1'b0;
      fbw_wren      <= 1'b0;
      frame_swap    <= 1'b0;
    end else begin
      fbw_row_addr  <= own_row_addr;
      fbw_col_addr  <= own_col_addr;
      fbw_data      <= own_data;
      fbw_row_store <= own_row_store && routed;
      fbw_row_swap  <= own_row_swap && routed;
      fbw_wren      <= own_wren && routed;
      frame_swap    <= own_frame_swap && routed;
    end
  end

  assign switching = (state != ST_RUN);

`ifdef FBW_MUX_TIMEOUT_EN
  hub75_fbw_mux_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (state == ST_DRAIN),
    .expired (timeout_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_flag <= 1'b0;
    end else if (go_gap && timeout_hit) begin
      timeout_flag <= 1'b1;
    end
  end
`else
  // No drain counter in this build: DRAIN waits for the owner's frame swap.
  assign timeout_hit  = 1'b0 && (TIMEOUT_CYCLES == 0);
  assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_hub75_fbw_mux.sv
// Self-checking bench for hub75_fbw_mux (3 sources, DEFAULT_SRC=1); timeout scenario runs when FBW_MUX_TIMEOUT_EN is defined.
module tb_hub75_fbw_mux;

  localparam int N_SRC = 3;
  localparam int LR    = 6;
  localparam int LC    = 9;
  localparam int BD    = 16;
  localparam int LS    = 2;
  localparam int DEF   = 1;
`ifdef FBW_MUX_TIMEOUT_EN
  localparam int TO    = 100;
`else
  localparam int TO    = 1 << 20;
`endif

  logic clk, rst_n;
  logic [N_SRC*LR-1:0] src_row_addr;
  logic [N_SRC-1:0]    src_row_store, src_row_swap, src_row_rdy;
  logic [N_SRC*BD-1:0] src_data;
  logic [N_SRC*LC-1:0] src_col_addr;
  logic [N_SRC-1:0]    src_wren, src_frame_swap, src_frame_rdy;
  logic [LR-1:0]       fbw_row_addr;
  logic                fbw_row_store, fbw_row_swap, fbw_wren, frame_swap;
  logic [BD-1:0]       fbw_data;
  logic [LC-1:0]       fbw_col_addr;
  logic                fbw_row_rdy, frame_rdy;
  logic [LS-1:0]       sel, active;
  logic                sel_req, switching, timeout_flag;

  hub75_fbw_mux #(
    .N_SRC(N_SRC), .N_ROWS(64), .N_COLS(384), .BITDEPTH(BD),
    .DEFAULT_SRC(DEF), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .src_row_addr(src_row_addr), .src_row_store(src_row_store), .src_row_swap(src_row_swap),
    .src_row_rdy(src_row_rdy), .src_data(src_data), .src_col_addr(src_col_addr),
    .src_wren(src_wren), .src_frame_swap(src_frame_swap), .src_frame_rdy(src_frame_rdy),
    .fbw_row_addr(fbw_row_addr), .fbw_row_store(fbw_row_store), .fbw_row_swap(fbw_row_swap),
    .fbw_data(fbw_data), .fbw_col_addr(fbw_col_addr), .fbw_wren(fbw_wren),
    .frame_swap(frame_swap), .fbw_row_rdy(fbw_row_rdy), .frame_rdy(frame_rdy),
    .sel(sel), .sel_req(sel_req), .active(active), .switching(switching),
    .timeout_flag(timeout_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the port, whether a switch is waiting for a frame
  // boundary, the one-cycle handover gap, and what the sink should see next.
  int          m_owner, m_pending, m_drain_cycles;
  bit          m_drain, m_gap, m_flag, m_routed;
  logic [N_SRC-1:0] e_row_rdy, e_frame_rdy;
  logic [LR-1:0] e_row;
  logic [LC-1:0] e_col;
  logic [BD-1:0] e_data;
  logic          e_store, e_swap, e_wren, e_fswap;

  task automatic model_reset();
    m_owner = DEF; m_pending = DEF; m_drain_cycles = 0;
    m_drain = 0; m_gap = 0; m_flag = 0; m_routed = 0;
    e_row = '0; e_col = '0; e_data = '0;
    e_store = 0; e_swap = 0; e_wren = 0; e_fswap = 0;
  endtask

  task automatic clear_inputs();
    src_row_addr = '0; src_row_store = '0; src_row_swap = '0; src_data = '0;
    src_col_addr = '0; src_wren = '0; src_frame_swap = '0;
    fbw_row_rdy = 1'b0; frame_rdy = 1'b0; sel = '0; sel_req = 1'b0;
  endtask

  // Expected source readies for the inputs currently applied.
  bit m_leaving, m_to_hit;
  task automatic model_eval();
    bit accepted, cancel;
    accepted  = m_drain && e_fswap && frame_rdy;
    cancel    = m_drain && sel_req && (int'(sel) == m_owner);
`ifdef FBW_MUX_TIMEOUT_EN
    m_to_hit  = m_drain && (m_drain_cycles == TO - 1);
`else
    m_to_hit  = 0;
`endif
    m_leaving = m_drain && !cancel && (accepted || m_to_hit);
    m_routed  = rst_n && !m_gap && !m_leaving;
    e_row_rdy = '0;
    e_frame_rdy = '0;
    if (m_routed) begin
      e_row_rdy[m_owner]   = fbw_row_rdy && !(e_store || e_swap);
      e_frame_rdy[m_owner] = frame_rdy && !e_fswap;
    end
  endtask

  // Advance one clock: derive the model's next view from the applied inputs, then clock.
  task automatic tick();
    logic [LR-1:0] n_row;
    logic [LC-1:0] n_col;
    logic [BD-1:0] n_data;
    logic n_store, n_swap, n_wren, n_fswap;
    int n_owner, n_pending, n_cnt;
    bit n_drain, n_gap, n_flag, sel_ok;
    model_eval();
    n_row   = src_row_addr[m_owner*LR +: LR];
    n_col   = src_col_addr[m_owner*LC +: LC];
    n_data  = src_data[m_owner*BD +: BD];
    n_store = src_row_store[m_owner] && m_routed;
    n_swap  = src_row_swap[m_owner] && m_routed;
    n_wren  = src_wren[m_owner] && m_routed;
    n_fswap = src_frame_swap[m_owner] && m_routed;
    n_owner = m_owner; n_pending = m_pending; n_drain = m_drain; n_gap = 0;
    n_cnt = m_drain_cycles + 1; n_flag = m_flag;
    sel_ok = sel_req && (int'(sel) < N_SRC);
    if (m_gap) begin
      n_owner = m_pending;
    end else if (!m_drain) begin
      if (sel_ok && int'(sel) != m_owner) begin
        n_drain = 1; n_pending = int'(sel); n_cnt = 0;
      end
    end else if (sel_ok && int'(sel) == m_owner) begin
      n_drain = 0;
    end else begin
      if (sel_ok) n_pending = int'(sel);
      if (m_leaving) begin
        n_drain = 0; n_gap = 1;
        if (m_to_hit) n_flag = 1;
      end
    end
    @(posedge clk);
    e_row = n_row; e_col = n_col; e_data = n_data;
    e_store = n_store; e_swap = n_swap; e_wren = n_wren; e_fswap = n_fswap;
    m_owner = n_owner; m_pending = n_pending; m_drain = n_drain; m_gap = n_gap;
    m_drain_cycles = n_cnt; m_flag = n_flag;
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    fbw_row_rdy = 1'b1;
    frame_rdy = 1'b1;
    model_reset();
    @(negedge clk);
    checks++;
    if (active !== 2'(DEF) || switching !== 1'b0 || timeout_flag !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_status: active=%0d switching=%b timeout=%b, expected %0d 0 0",
               active, switching, timeout_flag, DEF);
    end
    checks++;
    if ({fbw_row_addr, fbw_row_store, fbw_row_swap, fbw_data, fbw_col_addr, fbw_wren, frame_swap} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: sink side not all zero");
    end
    checks++;
    if (src_row_rdy !== 3'b000 || src_frame_rdy !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_rdy: row_rdy=%b frame_rdy=%b, expected 000 000", src_row_rdy, src_frame_rdy);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (src_row_rdy !== 3'b010 || src_frame_rdy !== 3'b010) begin
      errors++;
      $display("[TB] FAIL post_reset_rdy: row_rdy=%b frame_rdy=%b, expected 010 010", src_row_rdy, src_frame_rdy);
    end
  endtask

  task automatic test_write();
    fbw_row_rdy = 1'b1;
    src_col_addr[1*LC +: LC] = 9'd5;
    src_data[1*BD +: BD]     = 16'hBEEF;
    src_wren[1]              = 1'b1;
    src_col_addr[0 +: LC]    = 9'd7;
    src_data[0 +: BD]        = 16'h1234;
    src_wren[0]              = 1'b1;
    tick();
    checks++;
    if (fbw_col_addr !== 9'd5 || fbw_data !== 16'hBEEF || fbw_wren !== 1'b1) begin
      errors++;
      $display("[TB] FAIL write_owner: col=%0d data=%h wren=%b, expected 5 beef 1", fbw_col_addr, fbw_data, fbw_wren);
    end
    src_wren[1] = 1'b0;
    tick();
    checks++;
    if (fbw_wren !== 1'b0 || fbw_data !== 16'hBEEF) begin
      errors++;
      $display("[TB] FAIL write_non_owner: wren=%b data=%h, expected 0 beef", fbw_wren, fbw_data);
    end
    clear_inputs();
  endtask

  task automatic test_row_store();
    fbw_row_rdy = 1'b1;
    src_row_addr[1*LR +: LR] = 6'd17;
    src_row_store[1] = 1'b1;
    tick();
    src_row_store[1] = 1'b0;
    #1;
    checks++;
    if (fbw_row_store !== 1'b1 || fbw_row_addr !== 6'd17 || src_row_rdy !== 3'b000) begin
      errors++;
      $display("[TB] FAIL row_store_mask: store=%b addr=%0d rdy=%b, expected 1 17 000",
               fbw_row_store, fbw_row_addr, src_row_rdy);
    end
    tick();
    checks++;
    if (fbw_row_store !== 1'b0 || src_row_rdy !== 3'b010) begin
      errors++;
      $display("[TB] FAIL row_store_release: store=%b rdy=%b, expected 0 010", fbw_row_store, src_row_rdy);
    end
    clear_inputs();
  endtask

  task automatic test_switch();
    fbw_row_rdy = 1'b1;
    frame_rdy = 1'b1;
    sel = 2'd2;
    sel_req = 1'b1;
    tick();
    sel_req = 1'b0;
    checks++;
    if (switching !== 1'b1 || active !== 2'd1) begin
      errors++;
      $display("[TB] FAIL switch_drain: switching=%b active=%0d, expected 1 1", switching, active);
    end
    src_data[1*BD +: BD] = 16'h1111;
    src_wren[1] = 1'b1;
    tick();
    src_wren[1] = 1'b0;
    checks++;
    if (fbw_data !== 16'h1111 || fbw_wren !== 1'b1 || src_frame_rdy !== 3'b010) begin
      errors++;
      $display("[TB] FAIL switch_routed: data=%h wren=%b frame_rdy=%b, expected 1111 1 010",
               fbw_data, fbw_wren, src_frame_rdy);
    end
    src_frame_swap[1] = 1'b1;
    tick();
    src_frame_swap[1] = 1'b0;
    #1;
    checks++;
    if (frame_swap !== 1'b1 || src_frame_rdy !== 3'b000 || src_row_rdy !== 3'b000 || switching !== 1'b1) begin
      errors++;
      $display("[TB] FAIL switch_accept: frame_swap=%b frame_rdy=%b row_rdy=%b switching=%b, expected 1 000 000 1",
               frame_swap, src_frame_rdy, src_row_rdy, switching);
    end
    tick();
    checks++;
    if (switching !== 1'b1 || active !== 2'd1 || src_row_rdy !== 3'b000 ||
        {fbw_row_store, fbw_row_swap, fbw_wren, frame_swap} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL switch_gap: switching=%b active=%0d rdy=%b strobes=%b, expected 1 1 000 0000",
               switching, active, src_row_rdy, {fbw_row_store, fbw_row_swap, fbw_wren, frame_swap});
    end
    tick();
    checks++;
    if (switching !== 1'b0 || active !== 2'd2 || src_row_rdy !== 3'b100) begin
      errors++;
      $display("[TB] FAIL switch_done: switching=%b active=%0d rdy=%b, expected 0 2 100", switching, active, src_row_rdy);
    end
    clear_inputs();
  endtask

  task automatic test_invalid_sel();
    sel = 2'd3;
    sel_req = 1'b1;
    tick();
    checks++;
    if (switching !== 1'b0 || active !== 2'd2) begin
      errors++;
      $display("[TB] FAIL sel_out_of_range: switching=%b active=%0d, expected 0 2", switching, active);
    end
    sel = 2'd2;
    tick();
    sel_req = 1'b0;
    checks++;
    if (switching !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sel_same_owner: switching=%b, expected 0", switching);
    end
    sel = 2'd0;
    sel_req = 1'b1;
    tick();
    sel = 2'd2;
    tick();
    sel_req = 1'b0;
    checks++;
    if (switching !== 1'b0 || active !== 2'd2) begin
      errors++;
      $display("[TB] FAIL switch_cancel: switching=%b active=%0d, expected 0 2", switching, active);
    end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    fbw_row_rdy = 1'b1;
    src_row_store[2] = 1'b1;
    tick();
    src_row_store[2] = 1'b0;
    checks++;
    if (fbw_row_store !== 1'b1) begin
      errors++;
      $display("[TB] FAIL async_reset_setup: store=%b, expected 1", fbw_row_store);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (fbw_row_store !== 1'b0 || src_row_rdy !== 3'b000 || active !== 2'(DEF)) begin
      errors++;
      $display("[TB] FAIL async_reset_drop: store=%b rdy=%b active=%0d, expected 0 000 %0d",
               fbw_row_store, src_row_rdy, active, DEF);
    end
    model_reset();
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 800; cyc++) begin
      fbw_row_rdy = ($urandom_range(0, 3) != 0);
      frame_rdy   = $urandom_range(0, 1);
      sel_req     = ($urandom_range(0, 11) == 0);
      sel         = 2'($urandom_range(0, 3));
      src_row_addr = {$urandom, $urandom};
      src_col_addr = {$urandom, $urandom};
      src_data     = {$urandom, $urandom};
      model_eval();
      for (int i = 0; i < N_SRC; i++) begin
        if (i == m_owner) begin
          int r;
          r = $urandom_range(0, 3);
          src_row_store[i]  = e_row_rdy[i] && (r == 1);
          src_row_swap[i]   = e_row_rdy[i] && (r == 2);
          src_frame_swap[i] = e_frame_rdy[i] && ($urandom_range(0, 5) == 0);
        end else begin
          src_row_store[i]  = $urandom_range(0, 1);
          src_row_swap[i]   = $urandom_range(0, 1);
          src_frame_swap[i] = $urandom_range(0, 1);
        end
        src_wren[i] = $urandom_range(0, 1);
      end
      #1;
      checks++;
      if (src_row_rdy !== e_row_rdy || src_frame_rdy !== e_frame_rdy) begin
        errors++;
        $display("[TB] FAIL rand_rdy cyc %0d: row=%b frame=%b, expected %b %b",
                 cyc, src_row_rdy, src_frame_rdy, e_row_rdy, e_frame_rdy);
      end
      checks++;
      if ({fbw_row_addr, fbw_row_store, fbw_row_swap, fbw_data, fbw_col_addr, fbw_wren, frame_swap} !==
          {e_row, e_store, e_swap, e_data, e_col, e_wren, e_fswap}) begin
        errors++;
        $display("[TB] FAIL rand_sink cyc %0d: got %h expected %h", cyc,
                 {fbw_row_addr, fbw_row_store, fbw_row_swap, fbw_data, fbw_col_addr, fbw_wren, frame_swap},
                 {e_row, e_store, e_swap, e_data, e_col, e_wren, e_fswap});
      end
      checks++;
      if (active !== 2'(m_owner) || switching !== (m_drain || m_gap) || timeout_flag !== m_flag) begin
        errors++;
        $display("[TB] FAIL rand_status cyc %0d: active=%0d switching=%b timeout=%b, expected %0d %b %b",
                 cyc, active, switching, timeout_flag, m_owner, m_drain || m_gap, m_flag);
      end
      tick();
    end
    clear_inputs();
  endtask

`ifdef FBW_MUX_TIMEOUT_EN
  task automatic test_timeout();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    frame_rdy = 1'b1;
    sel = 2'd0;
    sel_req = 1'b1;
    tick();
    sel_req = 1'b0;
    repeat (TO - 1) tick();
    checks++;
    if (switching !== 1'b1 || timeout_flag !== 1'b0 || active !== 2'd1) begin
      errors++;
      $display("[TB] FAIL timeout_early: switching=%b timeout=%b active=%0d, expected 1 0 1",
               switching, timeout_flag, active);
    end
    tick();
    checks++;
    if (switching !== 1'b1 || timeout_flag !== 1'b1 || active !== 2'd1) begin
      errors++;
      $display("[TB] FAIL timeout_gap: switching=%b timeout=%b active=%0d, expected 1 1 1",
               switching, timeout_flag, active);
    end
    tick();
    checks++;
    if (switching !== 1'b0 || timeout_flag !== 1'b1 || active !== 2'd0) begin
      errors++;
      $display("[TB] FAIL timeout_done: switching=%b timeout=%b active=%0d, expected 0 1 0",
               switching, timeout_flag, active);
    end
    clear_inputs();
  endtask
`endif

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_write();
    test_row_store();
    test_switch();
    test_invalid_sel();
    test_async_reset();
    test_random();
`ifdef FBW_MUX_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
